// File: rtl/mem_pkg.sv
//------------------------------------------------------------------------------
// Module  : mem_pkg
// Purpose : Shared definitions for the multicycle memory access unit:
//           controller state encoding, default read latency and the
//           instruction opcode values decoded from IR.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_READ_WAIT = 3'd1,
    ST_CAPTURE   = 3'd2,
    ST_WRITE     = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

  localparam int READ_LATENCY_DEF = 2;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

endpackage

`default_nettype wire

// File: rtl/mem_access_unit.sv
//------------------------------------------------------------------------------
// Module  : mem_access_unit
// Purpose : Single-request memory access sequencer for a multicycle CPU.
//           Accepts one read (into IR or MDR) or one store per request,
//           drives a registered memory address/strobe and pulses Done.
// Ports   : Clock, Reset (sync, active-low)
//           ReqValid/ReqWrite/ReqInstr/IouD - request from controller
//           PC, ALUOut, WrData, MemRdData   - address/data sources
//           ReqReady, Done                  - handshake
//           MemAddr, MemWr, MemWrData       - memory side
//           IR, MDR, OpCode, Funct          - captured read data
//           AlignErr                        - sticky misalignment flag
// Config  : define MEM_ALIGN_CHK_EN to enable word-alignment checking.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_access_unit
  import mem_pkg::*;
#(
  parameter int READ_LATENCY = READ_LATENCY_DEF  // legal range 1..7
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        ReqValid,
  input  logic        ReqWrite,
  input  logic        ReqInstr,
  input  logic        IouD,
  input  logic [31:0] PC,
  input  logic [31:0] ALUOut,
  input  logic [31:0] WrData,
  input  logic [31:0] MemRdData,
  output logic        ReqReady,
  output logic        Done,
  output logic [31:0] MemAddr,
  output logic        MemWr,
  output logic [31:0] MemWrData,
  output logic [31:0] IR,
  output logic [31:0] MDR,
  output logic [5:0]  OpCode,
  output logic [5:0]  Funct,
  output logic        AlignErr
);

  // Counter preload: the wait state is occupied READ_LATENCY cycles in total.
  localparam logic [2:0] c_CNT_LOAD = 3'(READ_LATENCY - 1);

  state_t      r_state;
  logic [2:0]  r_cnt;
  logic        r_instr;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_ir;
  logic [31:0] r_mdr;
  logic        r_wr;
  logic        r_done;

  logic [31:0] w_addr;
  logic        w_misalign;

  assign w_addr = IouD ? ALUOut : PC;

`ifdef MEM_ALIGN_CHK_EN
  logic r_align;
  assign w_misalign = |w_addr[1:0];
  assign AlignErr   = r_align;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_align <= 1'b0;
    end else if (r_state == ST_IDLE && ReqValid && w_misalign) begin
      r_align <= 1'b1;
    end
  end
`else
  assign w_misalign = 1'b0;
  assign AlignErr   = 1'b0;
`endif

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 3'd0;
      r_instr <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_ir    <= 32'd0;
      r_mdr   <= 32'd0;
      r_wr    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      // Strobes are single-cycle; only the transitions below raise them.
      r_wr   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (ReqValid) begin
            r_addr  <= w_addr;
            r_instr <= ReqInstr;
            r_wdata <= WrData;
            if (ReqWrite) begin
              // A misaligned store is dropped: no strobe, straight to DONE.
              if (w_misalign) begin
                r_done  <= 1'b1;
                r_state <= ST_DONE;
              end else begin
                r_wr    <= 1'b1;
                r_state <= ST_WRITE;
              end
            end else begin
              r_cnt   <= c_CNT_LOAD;
              r_state <= ST_READ_WAIT;
            end
          end
        end
        ST_READ_WAIT: begin
          if (r_cnt == 3'd0) begin
            r_state <= ST_CAPTURE;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        ST_CAPTURE: begin
          if (r_instr) begin
            r_ir <= MemRdData;
          end else begin
            r_mdr <= MemRdData;
          end
          r_done  <= 1'b1;
          r_state <= ST_DONE;
        end
        ST_WRITE: begin
          r_done  <= 1'b1;
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ReqReady  = (r_state == ST_IDLE);
  assign Done      = r_done;
  assign MemAddr   = r_addr;
  assign MemWr     = r_wr;
  assign MemWrData = r_wdata;
  assign IR        = r_ir;
  assign MDR       = r_mdr;
  assign OpCode    = r_ir[31:26];
  assign Funct     = r_ir[5:0];

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
//------------------------------------------------------------------------------
// Module  : tb_mem_access_unit
// Purpose : Self-checking bench for mem_access_unit: table of single
//           requests plus back-to-back, reset-abort and maximum-latency
//           sequences. Build with MEM_ALIGN_CHK_EN to exercise alignment.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_access_unit;
  import mem_pkg::*;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        ReqValid, ReqValid7;
  logic        ReqWrite, ReqInstr, IouD;
  logic [31:0] PC, ALUOut, WrData, MemRdData;

  logic        ReqReady, Done, MemWr, AlignErr;
  logic [31:0] MemAddr, MemWrData, IR, MDR;
  logic [5:0]  OpCode, Funct;

  logic        ReqReady7, Done7, MemWr7, AlignErr7;
  logic [31:0] MemAddr7, MemWrData7, IR7, MDR7;
  logic [5:0]  OpCode7, Funct7;

  int n_cmp = 0;
  int n_err = 0;

  always #5 Clock = ~Clock;

  mem_access_unit #(.READ_LATENCY(2)) dut (
    .Clock(Clock), .Reset(Reset), .ReqValid(ReqValid), .ReqWrite(ReqWrite),
    .ReqInstr(ReqInstr), .IouD(IouD), .PC(PC), .ALUOut(ALUOut),
    .WrData(WrData), .MemRdData(MemRdData), .ReqReady(ReqReady), .Done(Done),
    .MemAddr(MemAddr), .MemWr(MemWr), .MemWrData(MemWrData), .IR(IR),
    .MDR(MDR), .OpCode(OpCode), .Funct(Funct), .AlignErr(AlignErr)
  );

  mem_access_unit #(.READ_LATENCY(7)) dut7 (
    .Clock(Clock), .Reset(Reset), .ReqValid(ReqValid7), .ReqWrite(ReqWrite),
    .ReqInstr(ReqInstr), .IouD(IouD), .PC(PC), .ALUOut(ALUOut),
    .WrData(WrData), .MemRdData(MemRdData), .ReqReady(ReqReady7), .Done(Done7),
    .MemAddr(MemAddr7), .MemWr(MemWr7), .MemWrData(MemWrData7), .IR(IR7),
    .MDR(MDR7), .OpCode(OpCode7), .Funct(Funct7), .AlignErr(AlignErr7)
  );

  typedef struct {
    logic        wr;
    logic        instr;
    logic        iou;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    logic [31:0] exp_ir;
    logic [31:0] exp_mdr;
    logic [5:0]  exp_op;
    logic [5:0]  exp_fn;
    int          exp_lat;
    int          exp_wrs;
    logic        exp_align;
  } vec_t;

  vec_t vecs[7];

  function automatic vec_t mk(logic wr, logic instr, logic iou,
                              logic [31:0] pc, logic [31:0] alu,
                              logic [31:0] wdata, logic [31:0] rdata,
                              logic [31:0] ea, logic [31:0] eir,
                              logic [31:0] emdr, logic [5:0] eop,
                              logic [5:0] efn, int elat, int ewrs,
                              logic ealign);
    vec_t v;
    v.wr = wr; v.instr = instr; v.iou = iou; v.pc = pc; v.alu = alu;
    v.wdata = wdata; v.rdata = rdata; v.exp_addr = ea; v.exp_ir = eir;
    v.exp_mdr = emdr; v.exp_op = eop; v.exp_fn = efn; v.exp_lat = elat;
    v.exp_wrs = ewrs; v.exp_align = ealign;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, exp);
    end
  endtask

  // Issue one request on the main DUT and follow it to Done (bounded).
  task automatic do_req(input vec_t v, output int lat, output int wrs,
                        output logic [31:0] wr_addr);
    @(negedge Clock);
    chk("ready_before_req", {31'd0, ReqReady}, 32'd1);
    ReqWrite = v.wr; ReqInstr = v.instr; IouD = v.iou; PC = v.pc;
    ALUOut = v.alu; WrData = v.wdata; MemRdData = v.rdata; ReqValid = 1'b1;
    @(negedge Clock);
    ReqValid = 1'b0;
    lat = -1; wrs = 0; wr_addr = 32'hXXXX_XXXX;
    for (int c = 1; c <= 20; c++) begin
      if (MemWr) begin
        wrs++;
        wr_addr = MemAddr;
      end
      if (Done) begin
        lat = c;
        break;
      end
      @(negedge Clock);
    end
  endtask

  initial begin
    int lat, wrs, acc, dones;
    logic [31:0] wa;
    logic prev_done, bad_accept;

    Reset = 1'b0; ReqValid = 1'b0; ReqValid7 = 1'b0; ReqWrite = 1'b0;
    ReqInstr = 1'b0; IouD = 1'b0; PC = '0; ALUOut = '0; WrData = '0;
    MemRdData = '0;

    //               wr   in   iou  pc          alu         wdata       rdata        addr        ir          mdr         op     fn     lat wrs al
    vecs[0] = mk(1'b0,1'b1,1'b0,32'h40,     32'h0,      32'h0,      32'h8C220004,32'h40,     32'h8C220004,32'h0,     6'h23, 6'h04, 4, 0, 1'b0);
    vecs[1] = mk(1'b0,1'b0,1'b1,32'h40,     32'h100,    32'h0,      32'hDEADBEEF,32'h100,    32'h8C220004,32'hDEADBEEF,6'h23,6'h04, 4, 0, 1'b0);
    vecs[2] = mk(1'b1,1'b0,1'b1,32'h40,     32'h200,    32'h12345678,32'h0,      32'h200,    32'h8C220004,32'hDEADBEEF,6'h23,6'h04, 2, 1, 1'b0);
    vecs[3] = mk(1'b0,1'b1,1'b0,32'h44,     32'h200,    32'h0,      32'h00221820,32'h44,     32'h00221820,32'hDEADBEEF,6'h00,6'h20, 4, 0, 1'b0);
    vecs[4] = mk(1'b1,1'b1,1'b0,32'h48,     32'h300,    32'hCAFEF00D,32'h0,      32'h48,     32'h00221820,32'hDEADBEEF,6'h00,6'h20, 2, 1, 1'b0);
    vecs[5] = mk(1'b0,1'b0,1'b0,32'h4C,     32'h300,    32'h0,      32'h0BADF00D,32'h4C,     32'h00221820,32'h0BADF00D,6'h00,6'h20, 4, 0, 1'b0);
`ifdef MEM_ALIGN_CHK_EN
    vecs[6] = mk(1'b1,1'b0,1'b1,32'h4C,     32'h202,    32'h55AA55AA,32'h0,      32'h202,    32'h00221820,32'h0BADF00D,6'h00,6'h20, 1, 0, 1'b1);
`else
    vecs[6] = mk(1'b1,1'b0,1'b1,32'h4C,     32'h202,    32'h55AA55AA,32'h0,      32'h202,    32'h00221820,32'h0BADF00D,6'h00,6'h20, 2, 1, 1'b0);
`endif

    // Reset state
    repeat (3) @(negedge Clock);
    chk("rst_ready",    {31'd0, ReqReady}, 32'd1);
    chk("rst_done",     {31'd0, Done},     32'd0);
    chk("rst_memwr",    {31'd0, MemWr},    32'd0);
    chk("rst_memaddr",  MemAddr,           32'd0);
    chk("rst_memwrdata",MemWrData,         32'd0);
    chk("rst_ir",       IR,                32'd0);
    chk("rst_mdr",      MDR,               32'd0);
    chk("rst_alignerr", {31'd0, AlignErr}, 32'd0);
    Reset = 1'b1;

    // Table of single requests
    for (int i = 0; i < 7; i++) begin
      do_req(vecs[i], lat, wrs, wa);
      chk($sformatf("v%0d_latency", i),   lat,       vecs[i].exp_lat);
      chk($sformatf("v%0d_memwr_cnt", i), wrs,       vecs[i].exp_wrs);
      if (wrs > 0) chk($sformatf("v%0d_wr_addr", i), wa, vecs[i].exp_addr);
      chk($sformatf("v%0d_memaddr", i),   MemAddr,   vecs[i].exp_addr);
      chk($sformatf("v%0d_memwrdata", i), MemWrData, vecs[i].wdata);
      chk($sformatf("v%0d_ir", i),        IR,        vecs[i].exp_ir);
      chk($sformatf("v%0d_mdr", i),       MDR,       vecs[i].exp_mdr);
      chk($sformatf("v%0d_opcode", i),    {26'd0, OpCode}, {26'd0, vecs[i].exp_op});
      chk($sformatf("v%0d_funct", i),     {26'd0, Funct},  {26'd0, vecs[i].exp_fn});
      chk($sformatf("v%0d_alignerr", i),  {31'd0, AlignErr}, {31'd0, vecs[i].exp_align});
      @(negedge Clock);
      chk($sformatf("v%0d_done_1cyc", i), {31'd0, Done},     32'd0);
      chk($sformatf("v%0d_ready_after", i), {31'd0, ReqReady}, 32'd1);
    end
    chk("fetch_opcode_lw", {26'd0, vecs[0].exp_op}, {26'd0, OP_LW});

    // Back-to-back: ReqValid held high for three full accesses (5 cycles each)
    @(negedge Clock);
    ReqWrite = 1'b0; ReqInstr = 1'b1; IouD = 1'b0; PC = 32'h80;
    MemRdData = 32'h11111111; ReqValid = 1'b1;
    acc = 0; dones = 0; prev_done = 1'b0; bad_accept = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (ReqReady) begin
        acc++;
        if (i > 0 && !prev_done) bad_accept = 1'b1;
      end
      if (Done) dones++;
      prev_done = Done;
      @(negedge Clock);
    end
    ReqValid = 1'b0;
    chk("b2b_accepts",    acc,   3);
    chk("b2b_dones",      dones, 3);
    chk("b2b_accept_gap", {31'd0, bad_accept}, 32'd0);
    chk("b2b_ir",         IR,    32'h11111111);

    // Reset during READ_WAIT aborts the read
    @(negedge Clock);
    PC = 32'h90; MemRdData = 32'h22222222; ReqInstr = 1'b1; ReqValid = 1'b1;
    @(negedge Clock);
    ReqValid = 1'b0;
    chk("abort_rd_busy", {31'd0, ReqReady}, 32'd0);
    Reset = 1'b0;
    @(negedge Clock);
    Reset = 1'b1;
    chk("abort_rd_ready", {31'd0, ReqReady}, 32'd1);
    chk("abort_rd_ir",    IR,      32'd0);
    chk("abort_rd_addr",  MemAddr, 32'd0);
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      if (Done) dones++;
      @(negedge Clock);
    end
    chk("abort_rd_no_done", dones, 0);

    // Reset while MemWr is high drops it on the same edge
    ReqWrite = 1'b1; IouD = 1'b1; ALUOut = 32'h400; WrData = 32'hA5A5A5A5;
    ReqValid = 1'b1;
    @(negedge Clock);
    ReqValid = 1'b0;
    chk("abort_wr_memwr_hi", {31'd0, MemWr}, 32'd1);
    Reset = 1'b0;
    @(negedge Clock);
    Reset = 1'b1;
    chk("abort_wr_memwr_lo", {31'd0, MemWr}, 32'd0);
    chk("abort_wr_done",     {31'd0, Done},  32'd0);

    // Maximum latency instance: fetch completes READ_LATENCY+2 = 9 cycles later
    @(negedge Clock);
    ReqWrite = 1'b0; ReqInstr = 1'b1; IouD = 1'b0; PC = 32'h60;
    MemRdData = 32'h00430820; ReqValid7 = 1'b1;
    @(negedge Clock);
    ReqValid7 = 1'b0;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      if (Done7) begin
        lat = c;
        break;
      end
      @(negedge Clock);
    end
    chk("lat7_latency", lat,      9);
    chk("lat7_ir",      IR7,      32'h00430820);
    chk("lat7_addr",    MemAddr7, 32'h60);
    chk("lat7_opcode",  {26'd0, OpCode7}, {26'd0, OP_RTYPE});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: READ_LATENCY, default 2, memory read latency in cycles, legal range 1..7.
REQ-002 Clock  in  1  system clock, all state updates on rising edge.
REQ-003 Reset  in  1  synchronous, active-low.
REQ-004 ReqValid  in  1  access request from controller.
REQ-005 ReqWrite  in  1  1 = store word, 0 = read.
REQ-006 ReqInstr  in  1  read destination: 1 = IR, 0 = MDR; ignored on writes.
REQ-007 IouD  in  1  address source: 0 = PC, 1 = ALUOut.
REQ-008 PC  in  32  instruction address.
REQ-009 ALUOut  in  32  data address.
REQ-010 WrData  in  32  store data (register B).
REQ-011 MemRdData  in  32  memory read bus.
REQ-012 ReqReady  out  1  unit idle, request accepted this cycle if ReqValid=1.
REQ-013 Done  out  1  one-cycle completion pulse.
REQ-014 MemAddr  out  32  registered memory address.
REQ-015 MemWr  out  1  memory write strobe.
REQ-016 MemWrData  out  32  registered store data.
REQ-017 IR  out  32  instruction register.
REQ-018 MDR  out  32  memory data register.
REQ-019 OpCode  out  6  IR[31:26].
REQ-020 Funct  out  6  IR[5:0].
REQ-021 AlignErr  out  1  sticky misalignment flag (MEM_ALIGN_CHK_EN only).

Function
REQ-022 States: IDLE, READ_WAIT, CAPTURE, WRITE, DONE.
REQ-023 IDLE: ReqReady=1; ReqValid=1 latches MemAddr from (IouD ? ALUOut : PC), ReqInstr, and WrData; go to WRITE if ReqWrite=1, else READ_WAIT.
REQ-024 READ_WAIT: 3-bit counter loads READ_LATENCY-1 on entry and decrements; go to CAPTURE at 0.
REQ-025 CAPTURE: load MemRdData into IR if ReqInstr=1, else into MDR; the other register holds; go to DONE.
REQ-026 WRITE: MemWr=1 for exactly one cycle, address and data stable; go to DONE.
REQ-027 DONE: Done=1 for one cycle; return to IDLE.
REQ-028 Read latency: ReqValid cycle to Done pulse is READ_LATENCY+2 cycles. Write latency: 2 cycles.
REQ-029 ReqReady=0 outside IDLE; ReqValid outside IDLE is ignored and not queued.
REQ-030 MemAddr, MemWrData, IR and MDR hold value in every state that does not load them.
REQ-031 OpCode and Funct are combinational slices of IR.
REQ-032 MemWr=0 in every state except WRITE.

Reset
REQ-033 Reset=0 at a rising edge forces IDLE, counter=0, MemAddr=0, MemWrData=0, IR=0, MDR=0, MemWr=0, Done=0, AlignErr=0.
REQ-034 Reset mid-access aborts it with no Done pulse; MemWr drops on the same edge.

Configuration
REQ-035 Macro MEM_ALIGN_CHK_EN defined: on acceptance, address[1:0]!=0 sets AlignErr (sticky until reset); reads complete normally; writes skip WRITE, go to DONE, and MemWr is never asserted.
REQ-036 Macro MEM_ALIGN_CHK_EN not defined: AlignErr tied 0; no alignment checking.

Structure
REQ-037 Shared package mem_pkg holds the state enum, READ_LATENCY default, and OpCode constants OP_RTYPE=6'h00, OP_LW=6'h23, OP_SW=6'h2B.
REQ-038 Single module; no sub-module.

Verification
REQ-039 Fetch: PC=0x40, IouD=0, ReqInstr=1, MemRdData=0x8C220004 -> MemAddr=0x40, IR=0x8C220004, OpCode=0x23, Done at cycle 4.
REQ-040 Load: ALUOut=0x100, IouD=1, ReqInstr=0, MemRdData=0xDEADBEEF -> MDR=0xDEADBEEF, IR unchanged.
REQ-041 Store: ALUOut=0x200, WrData=0x12345678, ReqWrite=1 -> MemWr=1 for exactly one cycle at 0x200, Done at cycle 2.
REQ-042 Back-to-back: ReqValid held high -> second request accepted only on the cycle after Done; no requests are lost or duplicated.
REQ-043 Reset=0 in READ_WAIT -> next cycle in IDLE with IR=0 and no Done pulse.
REQ-044 With MEM_ALIGN_CHK_EN: store to 0x202 -> AlignErr=1, MemWr stays 0, Done pulses.
